// File: rtl/word_selector_pkg.sv
// rtl/word_selector_pkg.sv - shared cache constants for byte-lane selection
//
// Holds the default lane width, the fixed lane count of a cache block,
// the block-offset width and the offset-to-lane encodings.
package word_selector_pkg;

    localparam int BYTE_WIDTH_DEFAULT = 8;
    localparam int NUM_LANES          = 4;
    localparam int OFFSET_WIDTH       = 2;

    localparam logic [OFFSET_WIDTH-1:0] LANE0 = 2'b00;
    localparam logic [OFFSET_WIDTH-1:0] LANE1 = 2'b01;
    localparam logic [OFFSET_WIDTH-1:0] LANE2 = 2'b10;
    localparam logic [OFFSET_WIDTH-1:0] LANE3 = 2'b11;

endpackage

// File: rtl/word_selector_byte_mux4.sv
// rtl/word_selector_byte_mux4.sv - combinational 4:1 byte-lane multiplexer
//
// Ports:
//   DATA0..DATA3  lane inputs
//   SEL           lane select (block offset)
//   OUT           selected lane
module byte_mux4
    import word_selector_pkg::*;
#(
    parameter int BYTE_WIDTH = BYTE_WIDTH_DEFAULT
) (
    input  logic [BYTE_WIDTH-1:0]   DATA0,
    input  logic [BYTE_WIDTH-1:0]   DATA1,
    input  logic [BYTE_WIDTH-1:0]   DATA2,
    input  logic [BYTE_WIDTH-1:0]   DATA3,
    input  logic [OFFSET_WIDTH-1:0] SEL,
    output logic [BYTE_WIDTH-1:0]   OUT
);

    always_comb begin
        OUT = DATA0;
        case (SEL)
            LANE0:   OUT = DATA0;
            LANE1:   OUT = DATA1;
            LANE2:   OUT = DATA2;
            LANE3:   OUT = DATA3;
            default: OUT = DATA0;
        endcase
    end

endmodule

// File: rtl/word_selector.sv
// rtl/word_selector.sv - byte-lane select, write merge and registered read byte
//
// Ports:
//   CLOCK, RESET_N      rising-edge clock, synchronous active-low reset
//   DATA0..DATA3        cache block lanes (DATA0 = block[BW-1:0])
//   OFFSET              block offset, ADDRESS[1:0]
//   OUT                 combinational selected byte
//   SEL_VALID           capture request for the registered read path
//   READDATA_Q          registered selected byte
//   READDATA_VALID      one-cycle pulse per capture
//   WRITEDATA           byte merged into lane OFFSET
//   MERGED_BLOCK        block with lane OFFSET replaced by WRITEDATA
//   BYTE_EN             one-hot decode of OFFSET
module word_selector
    import word_selector_pkg::*;
#(
    parameter int BYTE_WIDTH = BYTE_WIDTH_DEFAULT
) (
    input  logic                            CLOCK,
    input  logic                            RESET_N,
    input  logic [BYTE_WIDTH-1:0]           DATA0,
    input  logic [BYTE_WIDTH-1:0]           DATA1,
    input  logic [BYTE_WIDTH-1:0]           DATA2,
    input  logic [BYTE_WIDTH-1:0]           DATA3,
    input  logic [OFFSET_WIDTH-1:0]         OFFSET,
    output logic [BYTE_WIDTH-1:0]           OUT,
    input  logic                            SEL_VALID,
    output logic [BYTE_WIDTH-1:0]           READDATA_Q,
    output logic                            READDATA_VALID,
    input  logic [BYTE_WIDTH-1:0]           WRITEDATA,
    output logic [NUM_LANES*BYTE_WIDTH-1:0] MERGED_BLOCK,
    output logic [NUM_LANES-1:0]            BYTE_EN
);

    logic [BYTE_WIDTH-1:0] lanes [NUM_LANES];

    assign lanes[0] = DATA0;
    assign lanes[1] = DATA1;
    assign lanes[2] = DATA2;
    assign lanes[3] = DATA3;

    byte_mux4 #(
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_byte_mux4 (
        .DATA0 (DATA0),
        .DATA1 (DATA1),
        .DATA2 (DATA2),
        .DATA3 (DATA3),
        .SEL   (OFFSET),
        .OUT   (OUT)
    );

    assign BYTE_EN = 4'b0001 << OFFSET;

    // Byte enables drive the merge so the written lane and the decoded
    // enable can never disagree.
    always_comb begin
        MERGED_BLOCK = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            MERGED_BLOCK[i*BYTE_WIDTH +: BYTE_WIDTH] = BYTE_EN[i] ? WRITEDATA : lanes[i];
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            READDATA_Q     <= '0;
            READDATA_VALID <= 1'b0;
        end else if (SEL_VALID) begin
            READDATA_Q     <= OUT;
            READDATA_VALID <= 1'b1;
        end else begin
            READDATA_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_word_selector.sv
// tb/tb_word_selector.sv - self-checking bench for word_selector
module tb_word_selector;

    logic        CLOCK;
    logic        RESET_N;
    logic [7:0]  DATA0, DATA1, DATA2, DATA3;
    logic [1:0]  OFFSET;
    logic [7:0]  OUT;
    logic        SEL_VALID;
    logic [7:0]  READDATA_Q;
    logic        READDATA_VALID;
    logic [7:0]  WRITEDATA;
    logic [31:0] MERGED_BLOCK;
    logic [3:0]  BYTE_EN;

    int n_cmp = 0;
    int n_bad = 0;

    word_selector #(.BYTE_WIDTH(8)) dut (
        .CLOCK          (CLOCK),
        .RESET_N        (RESET_N),
        .DATA0          (DATA0),
        .DATA1          (DATA1),
        .DATA2          (DATA2),
        .DATA3          (DATA3),
        .OFFSET         (OFFSET),
        .OUT            (OUT),
        .SEL_VALID      (SEL_VALID),
        .READDATA_Q     (READDATA_Q),
        .READDATA_VALID (READDATA_VALID),
        .WRITEDATA      (WRITEDATA),
        .MERGED_BLOCK   (MERGED_BLOCK),
        .BYTE_EN        (BYTE_EN)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [7:0]  d0, d1, d2, d3;
        logic [1:0]  off;
        logic [7:0]  wd;
        logic [7:0]  e_out;
        logic [3:0]  e_be;
        logic [31:0] e_mrg;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_data(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        DATA0 = a; DATA1 = b; DATA2 = c; DATA3 = d;
    endtask

    task automatic edge_step;
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        logic [31:0] ref_mrg;
        logic [7:0]  ref_out;
        logic [3:0]  ref_be;
        logic [7:0]  exp_q;
        logic        exp_v;
        logic [7:0]  rd [4];

        RESET_N   = 1'b0;
        SEL_VALID = 1'b0;
        OFFSET    = 2'd0;
        WRITEDATA = 8'h00;
        set_data(8'h11, 8'h22, 8'h33, 8'h44);

        vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 2'd0, 8'hAB, 8'h11, 4'b0001, 32'h443322AB};
        vecs[1] = '{8'h11, 8'h22, 8'h33, 8'h44, 2'd1, 8'hAB, 8'h22, 4'b0010, 32'h4433AB11};
        vecs[2] = '{8'h11, 8'h22, 8'h33, 8'h44, 2'd2, 8'hAB, 8'h33, 4'b0100, 32'h44AB2211};
        vecs[3] = '{8'h11, 8'h22, 8'h33, 8'h44, 2'd3, 8'hAB, 8'h44, 4'b1000, 32'hAB332211};
        vecs[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 2'd1, 8'h00, 8'hAD, 4'b0010, 32'hEFBE00DE};
        vecs[5] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 2'd3, 8'h5A, 8'hFF, 4'b1000, 32'h5A00FF00};

        // Reset state
        edge_step();
        chk("reset_q", {24'h0, READDATA_Q}, 32'h0);
        chk("reset_valid", {31'h0, READDATA_VALID}, 32'h0);

        // Combinational vectors (held in reset: no reset dependency expected)
        for (int i = 0; i < 6; i++) begin
            set_data(vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3);
            OFFSET    = vecs[i].off;
            WRITEDATA = vecs[i].wd;
            #1;
            chk($sformatf("vec%0d_out", i), {24'h0, OUT}, {24'h0, vecs[i].e_out});
            chk($sformatf("vec%0d_be", i), {28'h0, BYTE_EN}, {28'h0, vecs[i].e_be});
            chk($sformatf("vec%0d_merged", i), MERGED_BLOCK, vecs[i].e_mrg);
        end

        // Reset held for 2 edges with SEL_VALID=1, OFFSET=3
        set_data(8'h11, 8'h22, 8'h33, 8'h44);
        OFFSET    = 2'd3;
        SEL_VALID = 1'b1;
        for (int i = 0; i < 2; i++) begin
            edge_step();
            chk("rst_dom_q", {24'h0, READDATA_Q}, 32'h0);
            chk("rst_dom_valid", {31'h0, READDATA_VALID}, 32'h0);
        end
        RESET_N = 1'b1;
        edge_step();
        chk("first_cap_q", {24'h0, READDATA_Q}, 32'h44);
        chk("first_cap_valid", {31'h0, READDATA_VALID}, 32'h1);

        // Back-to-back captures sweeping the offset
        rd[0] = 8'h11; rd[1] = 8'h22; rd[2] = 8'h33; rd[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            OFFSET = 2'(i);
            edge_step();
            chk($sformatf("b2b%0d_q", i), {24'h0, READDATA_Q}, {24'h0, rd[i]});
            chk($sformatf("b2b%0d_valid", i), {31'h0, READDATA_VALID}, 32'h1);
        end
        SEL_VALID = 1'b0;
        OFFSET    = 2'd1;
        edge_step();
        chk("hold_q", {24'h0, READDATA_Q}, 32'h44);
        chk("hold_valid", {31'h0, READDATA_VALID}, 32'h0);
        edge_step();
        chk("hold2_q", {24'h0, READDATA_Q}, 32'h44);

        // Data changes just before the capturing edge
        SEL_VALID = 1'b1;
        OFFSET    = 2'd2;
        @(negedge CLOCK);
        set_data(8'h11, 8'h22, 8'h9C, 8'h44);
        edge_step();
        chk("late_data_q", {24'h0, READDATA_Q}, 32'h9C);

        // Mid-stream reset with SEL_VALID still high
        OFFSET = 2'd1;
        edge_step();
        chk("pre_rst_q", {24'h0, READDATA_Q}, 32'h22);
        RESET_N = 1'b0;
        edge_step();
        chk("mid_rst_q", {24'h0, READDATA_Q}, 32'h0);
        chk("mid_rst_valid", {31'h0, READDATA_VALID}, 32'h0);
        RESET_N   = 1'b1;
        SEL_VALID = 1'b0;
        edge_step();
        exp_q = 8'h00;

        // Random sweep against a reference model
        for (int n = 0; n < 1000; n++) begin
            @(negedge CLOCK);
            set_data(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            OFFSET    = 2'($urandom_range(0, 3));
            WRITEDATA = 8'($urandom);
            SEL_VALID = 1'($urandom);
            #1;
            case (OFFSET)
                2'd0: begin ref_out = DATA0; ref_be = 4'b0001; ref_mrg = {DATA3, DATA2, DATA1, WRITEDATA}; end
                2'd1: begin ref_out = DATA1; ref_be = 4'b0010; ref_mrg = {DATA3, DATA2, WRITEDATA, DATA0}; end
                2'd2: begin ref_out = DATA2; ref_be = 4'b0100; ref_mrg = {DATA3, WRITEDATA, DATA1, DATA0}; end
                default: begin ref_out = DATA3; ref_be = 4'b1000; ref_mrg = {WRITEDATA, DATA2, DATA1, DATA0}; end
            endcase
            chk("rnd_out", {24'h0, OUT}, {24'h0, ref_out});
            chk("rnd_be", {28'h0, BYTE_EN}, {28'h0, ref_be});
            chk("rnd_merged", MERGED_BLOCK, ref_mrg);
            rd[0] = DATA0; rd[1] = DATA1; rd[2] = DATA2; rd[3] = DATA3;
            for (int l = 0; l < 4; l++) begin
                if (l != int'(OFFSET))
                    chk("rnd_passlane", {24'h0, MERGED_BLOCK[l*8 +: 8]}, {24'h0, rd[l]});
            end
            if (SEL_VALID) exp_q = ref_out;
            exp_v = SEL_VALID;
            edge_step();
            chk("rnd_q", {24'h0, READDATA_Q}, {24'h0, exp_q});
            chk("rnd_valid", {31'h0, READDATA_VALID}, {31'h0, exp_v});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
